store_buffer: RTL and testbench

Posted-write buffer between the pipeline's MEM-stage data port and the backing memory. CPU stores retire in one cycle into a small FIFO and drain to memory in the background. Loads are forwarded from the youngest matching buffered store, or fetched from memory while the pipeline is stalled. It lets the 5-stage CPU tolerate a multi-cycle memory without stalling on every store.

---
 rtl/sb_pkg.sv | 20 ++
 rtl/sb_fifo.sv | 74 +++++++
 rtl/store_buffer.sv | 127 ++++++++++++
 tb/tb_store_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types for the store buffer: FSM states and the buffered store entry.
package sb_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_WORD_W = SB_ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD
    } sb_state_e;

    // One posted store: word address (byte offset dropped) and its data.
    typedef struct packed {
        logic [SB_WORD_W-1:0] word;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO with a youngest-match search for load forwarding.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  sb_entry_t            push_entry,
    input  logic                 pop,
    input  logic [SB_WORD_W-1:0] lookup_word,
    output sb_entry_t            head_entry,
    output logic                 full,
    output logic                 empty,
    output logic                 hit,
    output logic [SB_DATA_W-1:0] hit_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] idx;

    // Entry storage: written at the tail on push.
    // NOTE: the storage array has no reset; validity comes from count, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_entry;
        end
    end

    // Head/tail pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = entries[head];

    // Walk valid entries oldest to youngest so the last match wins (youngest store).
    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].word == lookup_word)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: stores retire into a FIFO and drain in the background,
// loads forward from the youngest buffered store or stall for a memory read.
// Entry layout follows the sb_pkg widths; keep ADDR_W/DATA_W in step with them.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              empty
);

    sb_state_e         state;
    sb_entry_t         new_entry;
    sb_entry_t         head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [ADDR_W-3:0] cpu_word;
    logic              drain_done;
    logic              load_done;
    logic              load_miss;
    logic              store_ok;
    logic              unused_bits;

    assign cpu_word    = cpu_addr[ADDR_W-1:2];
    assign unused_bits = &{1'b0, cpu_addr[1:0]};

    assign drain_done = (state == DRAIN) && mem_ready;
    assign load_done  = (state == LOAD) && mem_ready;
    assign load_miss  = cpu_rd && !fwd_hit;
    // A full buffer still takes the store on the edge that retires the head entry.
    assign store_ok   = cpu_wr && !cpu_rd && (!fifo_full || drain_done);

    assign new_entry = '{word: cpu_word, data: cpu_wdata};

    sb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (store_ok),
        .push_entry (new_entry),
        .pop        (drain_done),
        .lookup_word(cpu_word),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    // CPU-side response: forwarded data, returning read data, or a stall.
    always_comb begin
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        if (cpu_rd) begin
            if (fwd_hit) begin
                cpu_rdata = fwd_data;
            end else if (load_done) begin
                cpu_rdata = mem_rdata;
            end else begin
                cpu_stall = 1'b1;
            end
        end else if (cpu_wr) begin
            cpu_stall = fifo_full && !drain_done;
        end
    end

    // Memory-side FSM with registered request outputs; a load miss beats draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= LOAD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_word, 2'b00};
                    end else if (!fifo_empty) begin
                        state     <= DRAIN;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {head_entry.word, 2'b00};
                        mem_wdata <= head_entry.data;
                    end
                end
                DRAIN, LOAD: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty = fifo_empty && (state == IDLE);

    // Simultaneous load and store is a pipeline bug; the load wins and the store is dropped.
    assert property (@(posedge clk) disable iff (!reset) !(cpu_rd && cpu_wr));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a latency-programmable memory model
// pops expected writes from a scoreboard, loads are checked against a
// program-order reference memory.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        empty;

    int total = 0;
    int bad   = 0;

    int mem_lat = 2;
    int lat_cnt = 0;
    int wr_done = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [63:0] wr_q [$];

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Memory: mem_ready pulses in the mem_lat-th cycle of a request; writes are
    // matched in order against the scoreboard (sentinel address when none expected).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready = 1'b0;
            lat_cnt   = 0;
        end else begin
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                lat_cnt   = 0;
            end else if (mem_req) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        logic [63:0] exp_wr;
                        exp_wr = (wr_q.size() != 0) ? wr_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                        check("mem_write", {mem_addr, mem_wdata}, exp_wr);
                        mem_model[mem_addr] = mem_wdata;
                        wr_done++;
                    end else begin
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                    end
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            output int stalls, output logic rdy_at_accept);
        int n = 0;
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_wr    = 1'b1;
        #1;
        while (cpu_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (cpu_stall) check("store_timeout", {63'h0, cpu_stall}, 64'h0);
        rdy_at_accept = mem_ready;
        stalls        = n;
        wr_q.push_back({addr & ~32'h3, data});
        ref_mem[addr & ~32'h3] = data;
        @(posedge clk);
        #1 cpu_wr = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, output int stalls,
                           output logic rdy_at_done, output logic saw_rd,
                           output logic [31:0] rd_addr, output int pend_wr);
        int n = 0;
        logic [31:0] exp_data;
        saw_rd  = 1'b0;
        rd_addr = '0;
        pend_wr = -1;
        exp_data = ref_mem.exists(addr & ~32'h3) ? ref_mem[addr & ~32'h3] : 32'h0;
        @(negedge clk);
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        #1;
        while (cpu_stall && n < 200) begin
            if (!saw_rd && mem_req && !mem_we) begin
                saw_rd  = 1'b1;
                rd_addr = mem_addr;
                pend_wr = wr_q.size();
            end
            n++;
            @(negedge clk);
            #1;
        end
        if (cpu_stall) check({tag, "_timeout"}, {63'h0, cpu_stall}, 64'h0);
        if (!saw_rd && mem_req && !mem_we) begin
            saw_rd  = 1'b1;
            rd_addr = mem_addr;
            pend_wr = wr_q.size();
        end
        check({tag, "_data"}, {32'h0, cpu_rdata}, {32'h0, exp_data});
        rdy_at_done = mem_ready;
        stalls      = n;
        @(posedge clk);
        #1 cpu_rd = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!mem_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ready) check({tag, "_ready_timeout"}, {63'h0, mem_ready}, 64'h1);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (!empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_empty"}, {63'h0, empty}, 64'h1);
    endtask

    initial begin
        int          st;
        logic        rdy;
        logic        saw;
        logic [31:0] raddr;
        int          pend;
        int          base;

        mem_model[32'h100] = 32'h1234_5678;
        ref_mem[32'h100]   = 32'h1234_5678;
        mem_model[32'h300] = 32'hCAFE_F00D;
        ref_mem[32'h300]   = 32'hCAFE_F00D;

        // Reset values
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",   {63'h0, mem_req},   64'h0);
        check("rst_mem_we",    {63'h0, mem_we},    64'h0);
        check("rst_mem_addr",  {32'h0, mem_addr},  64'h0);
        check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
        check("rst_stall",     {63'h0, cpu_stall}, 64'h0);
        check("rst_rdata",     {32'h0, cpu_rdata}, 64'h0);
        check("rst_empty",     {63'h0, empty},     64'h1);
        @(negedge clk);
        reset = 1'b1;

        // Single store: mem_req one cycle after acceptance, empty after the ready edge
        mem_lat = 2;
        do_store(32'h40, 32'hDEAD_BEEF, st, rdy);
        check("t1_stall", st, 0);
        check("t1_req_accept_cycle", {63'h0, mem_req}, 64'h0);
        @(posedge clk);
        #1;
        check("t1_req",   {63'h0, mem_req},   64'h1);
        check("t1_we",    {63'h0, mem_we},    64'h1);
        check("t1_addr",  {32'h0, mem_addr},  64'h40);
        check("t1_wdata", {32'h0, mem_wdata}, 64'hDEAD_BEEF);
        wait_ready("t1", 20);
        @(posedge clk);
        #1;
        check("t1_empty_after", {63'h0, empty}, 64'h1);

        // Two stores to one word, then a forwarded load of the youngest
        do_store(32'h80, 32'h11, st, rdy);
        check("t2_stall_a", st, 0);
        do_store(32'h80, 32'h22, st, rdy);
        check("t2_stall_b", st, 0);
        do_load("t2", 32'h80, st, rdy, saw, raddr, pend);
        check("t2_fwd_stall", st, 0);
        wait_empty("t2", 50);

        // Load miss, L=3: stall L cycles plus the returning cycle
        mem_lat = 3;
        do_load("t3", 32'h100, st, rdy, saw, raddr, pend);
        check("t3_stall", st, 3);
        check("t3_ready", {63'h0, rdy}, 64'h1);
        check("t3_read_req", {63'h0, saw}, 64'h1);
        check("t3_read_addr", {32'h0, raddr}, 64'h100);

        // Five back-to-back stores into a 4-deep buffer, L=6
        mem_lat = 6;
        for (int i = 0; i < 5; i++) begin
            do_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), st, rdy);
            if (i < 4) begin
                check($sformatf("t4_stall_%0d", i), st, 0);
            end else begin
                check("t4_stall_5th", st, 3);
                check("t4_accept_on_ready", {63'h0, rdy}, 64'h1);
            end
        end
        wait_empty("t4", 200);

        // Load miss while a drain is in flight, L=4
        mem_lat = 4;
        do_store(32'h400, 32'h4444_4444, st, rdy);
        @(posedge clk);
        do_load("t5", 32'h300, st, rdy, saw, raddr, pend);
        check("t5_stall", st, 8);
        check("t5_read_req", {63'h0, saw}, 64'h1);
        check("t5_read_addr", {32'h0, raddr}, 64'h300);
        check("t5_write_first", pend, 0);
        wait_empty("t5", 50);

        // Reset mid-drain with three entries buffered
        mem_lat = 8;
        do_store(32'h500, 32'h5000_0000, st, rdy);
        do_store(32'h504, 32'h5000_0004, st, rdy);
        do_store(32'h508, 32'h5000_0008, st, rdy);
        @(negedge clk);
        #2;
        check("t6_req_before", {63'h0, mem_req}, 64'h1);
        reset = 1'b0;
        #1;
        check("t6_req_async", {63'h0, mem_req}, 64'h0);
        check("t6_we_async",  {63'h0, mem_we},  64'h0);
        check("t6_empty",     {63'h0, empty},   64'h1);
        check("t6_stall",     {63'h0, cpu_stall}, 64'h0);
        wr_q.delete();
        ref_mem.delete(32'h500);
        ref_mem.delete(32'h504);
        ref_mem.delete(32'h508);
        base = wr_done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t6_no_writes", wr_done, base);
        check("t6_empty_after", {63'h0, empty}, 64'h1);

        // Recovery: store and forwarded load after reset
        mem_lat = 2;
        do_store(32'h600, 32'h5A5A_5A5A, st, rdy);
        do_load("t7", 32'h600, st, rdy, saw, raddr, pend);
        check("t7_fwd_stall", st, 0);
        wait_empty("t7", 50);
        check("wr_q_drained", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
